// File: rtl/key_event_queue_pkg.sv
// keyboard_pkg
// Shared definitions for the keyboard event path: the "no key" code, the
// auto-repeat state encoding and the default repeat timing for a 25.125 MHz
// system clock. Ports: none (package only).
package keyboard_pkg;

    localparam logic [15:0] KEY_NONE = 16'h0000;

    // 500 ms before the first repeat, 100 ms between later repeats.
    localparam int DEFAULT_DELAY_CYCLES = 12_562_500;
    localparam int DEFAULT_RATE_CYCLES  = 2_512_500;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } repeat_state_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// key_event_queue_if
// Bundles the key event queue's data and control signals.
//   key      : held key code from the PS/2 front end (0 = none)
//   pop      : one-cycle strobe removing the head entry
//   clear    : synchronous flush of queue and overflow flag
//   out      : head entry, 0 when empty
//   empty    : queue holds no entries
//   count    : number of entries held
//   overflow : sticky flag, set when a push was dropped
// master = producer/consumer side (CPU + keyboard), slave = the queue.
interface key_event_queue_if #(
    parameter int DEPTH = 8
) ();

    logic [15:0]            key;
    logic                   pop;
    logic                   clear;
    logic [15:0]            out;
    logic                   empty;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;

    modport master (
        output key, pop, clear,
        input  out, empty, count, overflow
    );

    modport slave (
        input  key, pop, clear,
        output out, empty, count, overflow
    );

endinterface

// File: rtl/key_event_queue_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with pointer-MSB full/empty detection. A push while full
// is accepted only if a pop happens in the same cycle (the pop frees the
// slot). A pop while empty is ignored. clear has priority over push and pop.
// DEPTH must be a power of two and at least 2.
//   clk, reset : clock, async active-high reset
//   push, pop  : write / read-advance requests
//   clear      : synchronous flush
//   din, dout  : write data / head data (0 when empty)
//   empty, full, count : occupancy status
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    // Same index with differing wrap bit means the writer is a full lap ahead.
    assign empty = (r_wrPtr == r_rdPtr);
    assign full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                   (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign count = r_wrPtr - r_rdPtr;

    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
            if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
        end
    end

    // Storage needs no reset: dout is masked to 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_doPush && !clear) r_mem[r_wrPtr[AW-1:0]] <= din;
    end

    assign dout = empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue
// Turns the level-style key code from the keyboard front end into discrete
// key events with typematic auto-repeat, queued for the Hack CPU.
// A new non-zero code pushes immediately; a held code pushes again after
// DELAY_CYCLES and then every RATE_CYCLES. DELAY_CYCLES and RATE_CYCLES
// must be at least 2; DEPTH a power of two, at least 2.
//   clk   : system clock
//   reset : async active-high reset
//   bus   : key/pop/clear in, out/empty/count/overflow out (slave side)
module key_event_queue
    import keyboard_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
    parameter int RATE_CYCLES  = DEFAULT_RATE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    key_event_queue_if.slave bus
);

    localparam int TW = $clog2(maxInt(DELAY_CYCLES, RATE_CYCLES));
    localparam logic [TW-1:0] TIMER_DELAY = TW'(DELAY_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_RATE  = TW'(RATE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

    repeat_state_t          r_state;
    repeat_state_t          w_stateNext;
    logic [TW-1:0]          r_timer;
    logic [TW-1:0]          w_timerNext;
    logic [15:0]            r_keyPrev;
    logic                   r_overflow;
    logic                   w_push;
    logic                   w_full;
    logic                   w_drop;
    logic [15:0]            w_out;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= RPT_IDLE;
            r_timer   <= '0;
            r_keyPrev <= KEY_NONE;
        end else begin
            r_state   <= w_stateNext;
            r_timer   <= w_timerNext;
            r_keyPrev <= bus.key;
        end
    end

    // A code differing from last cycle's is a fresh press (this includes a
    // shift/caps change while held) and restarts the initial delay.
    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        w_push      = 1'b0;
        if (bus.key == KEY_NONE) begin
            w_stateNext = RPT_IDLE;
        end else if (bus.key != r_keyPrev) begin
            w_push      = 1'b1;
            w_timerNext = TIMER_DELAY;
            w_stateNext = RPT_DELAY;
        end else if (r_state != RPT_IDLE) begin
            if (r_timer != '0) begin
                w_timerNext = r_timer - TIMER_ONE;
            end else begin
                w_push      = 1'b1;
                w_timerNext = TIMER_RATE;
                w_stateNext = RPT_REPEAT;
            end
        end
    end

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (bus.pop),
        .clear (bus.clear),
        .din   (bus.key),
        .dout  (w_out),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    // A push into a full queue is dropped unless a same-cycle pop frees a slot.
    assign w_drop = w_push && w_full && !bus.pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (bus.clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.out      = w_out;
    assign bus.empty    = w_empty;
    assign bus.count    = w_count;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue
// Directed scenarios plus a randomized run for key_event_queue, checked
// against a queue-based reference model that derives push events from how
// long the current key code has been held.
module tb_key_event_queue;

    localparam int DEPTH = 4;
    localparam int DELAY = 10;
    localparam int RATE  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] keyIn;
    logic        popIn;
    logic        clearIn;

    key_event_queue_if #(.DEPTH(DEPTH)) bus ();

    assign bus.key   = keyIn;
    assign bus.pop   = popIn;
    assign bus.clear = clearIn;

    key_event_queue #(
        .DEPTH        (DEPTH),
        .DELAY_CYCLES (DELAY),
        .RATE_CYCLES  (RATE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: queue contents, sticky overflow, last code, hold age.
    logic [15:0] mq[$];
    logic        mOverflow;
    logic [15:0] mPrev;
    int          mAge;

    task automatic modelReset();
        mq.delete();
        mOverflow = 1'b0;
        mPrev     = 16'h0;
        mAge      = 0;
    endtask

    function automatic logic [15:0] expHead();
        return (mq.size() != 0) ? mq[0] : 16'h0;
    endfunction

    // Advance one clock edge, update the model with the inputs seen at that
    // edge, then settle 1 time unit after the edge for sampling.
    task automatic tick();
        logic doPush;
        @(posedge clk);
        doPush = 1'b0;
        if (keyIn != 16'h0) begin
            if (keyIn != mPrev) begin
                doPush = 1'b1;
                mAge   = 0;
            end else begin
                mAge = mAge + 1;
                if (mAge == DELAY || (mAge > DELAY && (mAge - DELAY) % RATE == 0))
                    doPush = 1'b1;
            end
        end
        mPrev = keyIn;
        if (clearIn) begin
            mq.delete();
            mOverflow = 1'b0;
        end else begin
            if (popIn && mq.size() != 0) void'(mq.pop_front());
            if (doPush) begin
                if (mq.size() < DEPTH) mq.push_back(keyIn);
                else mOverflow = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        keyIn   = 16'h0;
        popIn   = 1'b0;
        clearIn = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        nChecks++; if (bus.out !== 16'h0) begin nFails++; $display("[TB] FAIL reset_out: got %h expected %h", bus.out, 16'h0); end
        nChecks++; if (bus.empty !== 1'b1) begin nFails++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); end
        nChecks++; if (bus.count !== 3'd0) begin nFails++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
        nChecks++; if (bus.overflow !== 1'b0) begin nFails++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.overflow); end
    endtask

    task automatic test_single_press();
        keyIn = 16'h0061;
        repeat (3) tick();
        keyIn = 16'h0;
        tick();
        nChecks++; if (bus.count !== 3'd1) begin nFails++; $display("[TB] FAIL single_count: got %0d expected 1", bus.count); end
        nChecks++; if (bus.out !== 16'h0061) begin nFails++; $display("[TB] FAIL single_out: got %h expected 0061", bus.out); end
        popIn = 1'b1;
        tick();
        popIn = 1'b0;
        nChecks++; if (bus.out !== 16'h0) begin nFails++; $display("[TB] FAIL single_pop_out: got %h expected 0000", bus.out); end
        nChecks++; if (bus.empty !== 1'b1) begin nFails++; $display("[TB] FAIL single_pop_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_auto_repeat();
        int expCount;
        keyIn = 16'h0061;
        for (int cyc = 0; cyc <= 21; cyc++) begin
            tick();
            expCount = 1 + int'(cyc >= 10) + int'(cyc >= 14) + int'(cyc >= 18);
            nChecks++;
            if (bus.count !== 3'(expCount)) begin
                nFails++;
                $display("[TB] FAIL repeat_count_c%0d: got %0d expected %0d", cyc, bus.count, expCount);
            end
        end
        nChecks++; if (bus.overflow !== 1'b0) begin nFails++; $display("[TB] FAIL repeat_no_overflow: got %b expected 0", bus.overflow); end
        tick();
        nChecks++; if (bus.count !== 3'd4) begin nFails++; $display("[TB] FAIL overflow_count: got %0d expected 4", bus.count); end
        nChecks++; if (bus.overflow !== 1'b1) begin nFails++; $display("[TB] FAIL overflow_set: got %b expected 1", bus.overflow); end
        clearIn = 1'b1;
        tick();
        clearIn = 1'b0;
        nChecks++; if (bus.count !== 3'd0) begin nFails++; $display("[TB] FAIL clear_count: got %0d expected 0", bus.count); end
        nChecks++; if (bus.overflow !== 1'b0) begin nFails++; $display("[TB] FAIL clear_overflow: got %b expected 0", bus.overflow); end
        keyIn = 16'h0;
        tick();
    endtask

    task automatic test_retrigger();
        keyIn = 16'h0061;
        for (int cyc = 0; cyc <= 4; cyc++) tick();
        keyIn = 16'h0041;
        tick();
        nChecks++; if (bus.count !== 3'd2) begin nFails++; $display("[TB] FAIL retrig_push_count: got %0d expected 2", bus.count); end
        for (int cyc = 6; cyc <= 15; cyc++) begin
            tick();
            nChecks++;
            if (bus.count !== ((cyc >= 15) ? 3'd3 : 3'd2)) begin
                nFails++;
                $display("[TB] FAIL retrig_count_c%0d: got %0d expected %0d", cyc, bus.count, (cyc >= 15) ? 3 : 2);
            end
        end
        keyIn = 16'h0;
        tick();
        nChecks++; if (bus.out !== 16'h0061) begin nFails++; $display("[TB] FAIL retrig_head: got %h expected 0061", bus.out); end
        popIn = 1'b1;
        tick();
        nChecks++; if (bus.out !== 16'h0041) begin nFails++; $display("[TB] FAIL retrig_second: got %h expected 0041", bus.out); end
        tick();
        nChecks++; if (bus.out !== 16'h0041) begin nFails++; $display("[TB] FAIL retrig_third: got %h expected 0041", bus.out); end
        tick();
        popIn = 1'b0;
        nChecks++; if (bus.empty !== 1'b1) begin nFails++; $display("[TB] FAIL retrig_drain: got %b expected 1", bus.empty); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] codes [5];
        codes = '{16'h0031, 16'h0032, 16'h0033, 16'h0034, 16'h0035};
        for (int i = 0; i < 4; i++) begin
            keyIn = codes[i];
            tick();
        end
        nChecks++; if (bus.count !== 3'd4) begin nFails++; $display("[TB] FAIL full_count: got %0d expected 4", bus.count); end
        keyIn = codes[4];
        popIn = 1'b1;
        tick();
        nChecks++; if (bus.count !== 3'd4) begin nFails++; $display("[TB] FAIL pushpop_full_count: got %0d expected 4", bus.count); end
        nChecks++; if (bus.out !== codes[1]) begin nFails++; $display("[TB] FAIL pushpop_full_head: got %h expected %h", bus.out, codes[1]); end
        nChecks++; if (bus.overflow !== 1'b0) begin nFails++; $display("[TB] FAIL pushpop_full_overflow: got %b expected 0", bus.overflow); end
        keyIn = 16'h0;
        for (int i = 2; i <= 5; i++) begin
            tick();
            nChecks++;
            if (bus.out !== ((i <= 4) ? codes[i] : 16'h0)) begin
                nFails++;
                $display("[TB] FAIL drain_out_%0d: got %h expected %h", i, bus.out, (i <= 4) ? codes[i] : 16'h0);
            end
        end
        tick();
        nChecks++; if (bus.count !== 3'd0) begin nFails++; $display("[TB] FAIL pop_empty_count: got %0d expected 0", bus.count); end
        nChecks++; if (bus.empty !== 1'b1) begin nFails++; $display("[TB] FAIL pop_empty_flag: got %b expected 1", bus.empty); end
        nChecks++; if (bus.overflow !== 1'b0) begin nFails++; $display("[TB] FAIL pop_empty_overflow: got %b expected 0", bus.overflow); end
        keyIn = 16'h0036;
        tick();
        popIn = 1'b0;
        keyIn = 16'h0;
        nChecks++; if (bus.count !== 3'd1) begin nFails++; $display("[TB] FAIL pushpop_empty_count: got %0d expected 1", bus.count); end
        nChecks++; if (bus.out !== 16'h0036) begin nFails++; $display("[TB] FAIL pushpop_empty_out: got %h expected 0036", bus.out); end
        popIn = 1'b1;
        tick();
        popIn = 1'b0;
    endtask

    task automatic test_reset_midrepeat();
        keyIn = 16'h0061;
        for (int cyc = 0; cyc <= 14; cyc++) tick();
        nChecks++; if (bus.count !== 3'd3) begin nFails++; $display("[TB] FAIL midrepeat_count: got %0d expected 3", bus.count); end
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        nChecks++; if (bus.count !== 3'd0) begin nFails++; $display("[TB] FAIL async_reset_count: got %0d expected 0", bus.count); end
        nChecks++; if (bus.out !== 16'h0) begin nFails++; $display("[TB] FAIL async_reset_out: got %h expected 0000", bus.out); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        nChecks++; if (bus.count !== 3'd1) begin nFails++; $display("[TB] FAIL post_reset_count: got %0d expected 1", bus.count); end
        nChecks++; if (bus.out !== 16'h0061) begin nFails++; $display("[TB] FAIL post_reset_out: got %h expected 0061", bus.out); end
        keyIn = 16'h0;
        popIn = 1'b1;
        tick();
        popIn = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] keySet [5];
        int holdLeft;
        keySet   = '{16'h0000, 16'h0061, 16'h0041, 16'h007a, 16'h0020};
        holdLeft = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (holdLeft == 0) begin
                keyIn    = keySet[$urandom_range(0, 4)];
                holdLeft = $urandom_range(1, 25);
            end
            popIn   = ($urandom_range(0, 3) == 0);
            clearIn = ($urandom_range(0, 39) == 0);
            tick();
            holdLeft--;
            nChecks++;
            if (bus.count !== 3'(mq.size())) begin
                nFails++;
                $display("[TB] FAIL rand_count_c%0d: got %0d expected %0d", cyc, bus.count, mq.size());
            end
            nChecks++;
            if (bus.out !== expHead()) begin
                nFails++;
                $display("[TB] FAIL rand_out_c%0d: got %h expected %h", cyc, bus.out, expHead());
            end
            nChecks++;
            if (bus.empty !== (mq.size() == 0)) begin
                nFails++;
                $display("[TB] FAIL rand_empty_c%0d: got %b expected %b", cyc, bus.empty, mq.size() == 0);
            end
            nChecks++;
            if (bus.overflow !== mOverflow) begin
                nFails++;
                $display("[TB] FAIL rand_overflow_c%0d: got %b expected %b", cyc, bus.overflow, mOverflow);
            end
        end
        popIn   = 1'b0;
        clearIn = 1'b0;
        keyIn   = 16'h0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_auto_repeat();
        test_retrigger();
        test_back_to_back();
        test_reset_midrepeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
